seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL take parameter CLK_DIV, default 100000, giving the number of clk cycles each digit slot lasts, including the blanking gap.
REQ-002 The block SHALL take parameter BLANK_CYC, default 4, giving the number of clk cycles all anodes are off at each digit change; the legal range is 1 to CLK_DIV-1.
REQ-003 Port clk SHALL be an input, 1 bit wide, and SHALL be the single system clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, and SHALL be the reset: asynchronous, active-high.
REQ-005 Port en SHALL be an input, 1 bit wide: display enable.
REQ-006 Port load SHALL be an input, 1 bit wide: a one-cycle strobe that captures din.
REQ-007 Port din SHALL be an input, 16 bits wide, carrying four BCD nibbles; [3:0] is digit 0, the rightmost digit.
REQ-008 Port blank_lz SHALL be an input, 1 bit wide: leading-zero suppression enable.
REQ-009 Port seg SHALL be an output, 7 bits wide, active-low, with bit order a..g on [6:0].
REQ-010 Port an SHALL be an output, 4 bits wide, active-low one-hot digit select.
REQ-011 Port frame_done SHALL be an output, 1 bit wide: a one-cycle pulse at each scan wrap.

Function
REQ-012 A divider counter SHALL count 0..CLK_DIV-1, wrap to 0, and assert an internal tick while at CLK_DIV-1.
REQ-013 A 2-bit digit index SHALL advance on each tick and wrap from 3 to 0.
REQ-014 The FSM SHALL have two states:
- BLANK: an = 4'b1111 for exactly BLANK_CYC cycles after a tick, then moves to SHOW.
- SHOW: drives an[idx] low and all other anodes high until the next tick, then moves to BLANK.
REQ-015 A load SHALL write din into a pending register and set pending_valid; a second load before transfer SHALL overwrite the pending value.
REQ-016 On the tick that wraps idx from 3 to 0, if pending_valid is set, the pending value SHALL be copied to the display register and pending_valid SHALL clear; a frame therefore never mixes old and new digits.
REQ-017 If load coincides with a transfer tick, the old pending value SHALL transfer and din SHALL become the new pending value with pending_valid set.
REQ-018 frame_done SHALL pulse high for one cycle on every 3-to-0 wrap tick, whether or not a transfer occurs.
REQ-019 seg SHALL be the 7-segment decode of the display nibble selected by idx, using the team's standard table (0 = 7'b0000001 ... 9 = 7'b0000100); nibbles 10..15 SHALL decode to 7'b1111111.
REQ-020 With blank_lz = 1, digit k (k = 3..1) SHALL show 7'b1111111 when it and every higher digit are zero; digit 0 SHALL never be suppressed.
REQ-021 With en = 0, an SHALL be 4'b1111, seg SHALL be 7'b1111111, and the divider, idx and FSM SHALL hold their values.
REQ-022 Loads SHALL still be accepted while en = 0, and transfer SHALL resume at the next wrap after en returns to 1.
REQ-023 seg and an SHALL be registered, giving one cycle of latency from an idx/state change to the pins.

Reset
REQ-024 While rst = 1, the block SHALL force: divider = 0, idx = 0, state = BLANK, an = 4'b1111, seg = 7'b1111111, frame_done = 0, display and pending registers = 16'h0000, pending_valid = 0.
REQ-025 A reset asserted mid-scan or mid-pending SHALL discard the pending data.
REQ-026 After rst deasserts, the first SHOW of digit 0 SHALL begin BLANK_CYC cycles later.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (BLANK, SHOW), the blank segment constant 7'b1111111, and the anode-off constant 4'b1111.
REQ-028 The decode SHALL be one instance of the existing bcd_7seg sub-module; the divider, FSM, registers and suppression logic SHALL be local to this block.

Verification
REQ-029 Reset scenario: with CLK_DIV = 8 and BLANK_CYC = 2, release rst -> an = 1111 for 2 cycles, then an = 1110 for 6 cycles, then 2 blank cycles, then an = 1101.
REQ-030 Frame-atomic load: load 16'h1234 mid-frame -> the display shows the old value until the wrap, then digits 4,3,2,1 on an 1110/1101/1011/0111 (digit 0 = 4 on an 1110); frame_done pulses once per wrap.
REQ-031 Load at the transfer tick: load 16'h5678, then load 16'h9999 on the wrap tick -> 5678 displays for one frame, then 9999 displays.
REQ-032 Leading-zero suppression: din = 16'h0070 with blank_lz = 1 -> digits 3 and 2 blank, digit 1 = 7'b0001111, digit 0 = 7'b0000001; with blank_lz = 0, digits 3 and 2 = 7'b0000001.
REQ-033 Invalid digit and disable: din = 16'h00A0 -> digit 1 shows 7'b1111111; with en = 0 for 20 cycles -> an = 1111 and idx is frozen, then resumes at the same slot when en returns to 1.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared types and constants for the digit scan controller
package seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low one-hot anode pattern for a digit index
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - control and pin bundle of the digit scan controller
interface seg_scan_ctrl_if;

    logic        en;
    logic        load;
    logic [15:0] din;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    modport master (
        output en, load, din, blank_lz,
        input  seg, an, frame_done
    );

    modport slave (
        input  en, load, din, blank_lz,
        output seg, an, frame_done
    );

endinterface

// File: rtl/seg_scan_ctrl_bcd_7seg.sv
// rtl/seg_scan_ctrl_bcd_7seg.sv - BCD to active-low 7-segment decode, a..g on [6:0]
module bcd_7seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Nibbles outside 0..9 light nothing
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = 7'b0000001;
            4'd1:    seg_o = 7'b1001111;
            4'd2:    seg_o = 7'b0010010;
            4'd3:    seg_o = 7'b0000110;
            4'd4:    seg_o = 7'b1001100;
            4'd5:    seg_o = 7'b0100100;
            4'd6:    seg_o = 7'b0100000;
            4'd7:    seg_o = 7'b0001111;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0000100;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit multiplexed 7-segment scanner with frame-atomic loads
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 4
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [1:0]       idx_q;
    state_t           state_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             frame_done_q;
    logic [15:0]      disp_q;
    logic [15:0]      pend_q;
    logic             pend_valid_q;

    logic             tick_d;
    logic             wrap_d;
    logic [3:0]       nib_d;
    logic [6:0]       dec_d;
    logic [3:0]       lz_d;
    logic [6:0]       seg_d;
    logic [3:0]       an_d;

    assign tick_d = bus.en && (div_q == DIV_LAST);
    assign wrap_d = tick_d && (idx_q == 2'd3);
    assign div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    // Pick the display nibble for the digit currently being scanned
    always_comb begin
        case (idx_q)
            2'd0:    nib_d = disp_q[3:0];
            2'd1:    nib_d = disp_q[7:4];
            2'd2:    nib_d = disp_q[11:8];
            default: nib_d = disp_q[15:12];
        endcase
    end

    bcd_7seg u_dec (
        .bcd_i (nib_d),
        .seg_o (dec_d)
    );

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows
    assign lz_d[3] = bus.blank_lz && (disp_q[15:12] == 4'h0);
    assign lz_d[2] = bus.blank_lz && (disp_q[15:8] == 8'h00);
    assign lz_d[1] = bus.blank_lz && (disp_q[15:4] == 12'h000);
    assign lz_d[0] = 1'b0;

    assign seg_d = lz_d[idx_q] ? SEG_BLANK : dec_d;
    assign an_d  = an_select(idx_q);

    // Divider, digit index and blank/show sequencing with registered pin outputs; all frozen while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= 2'd0;
            state_q      <= ST_BLANK;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else if (!bus.en) begin
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            frame_done_q <= wrap_d;
            if (tick_d) begin
                idx_q <= idx_q + 2'd1;
            end
            case (state_q)
                ST_BLANK: begin
                    an_q  <= AN_OFF;
                    seg_q <= SEG_BLANK;
                    if (div_q == BLANK_LAST) begin
                        state_q <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    an_q  <= an_d;
                    seg_q <= seg_d;
                    if (tick_d) begin
                        state_q <= ST_BLANK;
                    end
                end
                default: begin
                    an_q    <= AN_OFF;
                    seg_q   <= SEG_BLANK;
                    state_q <= ST_BLANK;
                end
            endcase
        end
    end

    // Loads park in the pending register; the display only changes at a frame wrap so a frame is never mixed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_valid_q <= 1'b0;
        end else begin
            if (wrap_d && pend_valid_q) begin
                disp_q       <= pend_q;
                pend_valid_q <= 1'b0;
            end
            if (bus.load) begin
                pend_q       <= bus.din;
                pend_valid_q <= 1'b1;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: enabled time since reset, display value and pending slot
    int          m_t    = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_pv   = 1'b0;
    bit          m_show = 1'b0;
    int          m_slot = 0;
    logic [3:0]  exp_an  = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    bit          exp_fd  = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] digit_seg(input logic [15:0] d, input int k, input bit lz);
        logic [15:0] upper;
        upper = d >> (4 * k);
        if (lz && k > 0 && upper == 16'h0) return 7'b1111111;
        return seg_of(upper[3:0]);
    endfunction

    // Outputs after each edge describe the slot position reached before that edge
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
                m_show = 1'b0; m_slot = 0;
                exp_an = 4'hF; exp_seg = 7'h7F; exp_fd = 1'b0;
            end else begin
                if (bus.en) begin
                    m_slot  = (m_t / CLK_DIV) % 4;
                    m_show  = (m_t % CLK_DIV) >= BLANK_CYC;
                    exp_an  = m_show ? ~(4'b0001 << m_slot) : 4'hF;
                    exp_seg = m_show ? digit_seg(m_disp, m_slot, bus.blank_lz) : 7'h7F;
                    exp_fd  = (m_t % FRAME) == FRAME - 1;
                    if (exp_fd && m_pv) begin
                        m_disp = m_pend;
                        m_pv   = 1'b0;
                    end
                    m_t++;
                end else begin
                    m_show = 1'b0; exp_an = 4'hF; exp_seg = 7'h7F; exp_fd = 1'b0;
                end
                if (bus.load) begin
                    m_pend = bus.din;
                    m_pv   = 1'b1;
                end
            end
        end
    end

    task automatic wait_t(input int target);
        int n;
        n = 0;
        @(negedge clk);
        while ((m_t % FRAME) != target && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if ((m_t % FRAME) != target) begin
            checks++; errors++;
            $display("FAIL wait_slot position %0d required %0d", m_t % FRAME, target);
        end
    endtask

    task automatic pulse_load(input logic [15:0] d);
        bus.din  = d;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] seq [11];
        seq = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
        rst = 1'b1; bus.en = 1'b1; bus.load = 1'b0; bus.din = 16'h0; bus.blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL reset_an got %b want 1111", bus.an); end
        checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b want 1111111", bus.seg); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", bus.frame_done); end
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (bus.an !== seq[i]) begin errors++; $display("FAIL reset_seq cycle %0d an got %b want %b", i, bus.an, seq[i]); end
            checks++;
            if ({bus.seg, bus.frame_done} !== {exp_seg, exp_fd}) begin
                errors++; $display("FAIL reset_seq cycle %0d seg/fd got %b/%b want %b/%b", i, bus.seg, bus.frame_done, exp_seg, exp_fd);
            end
        end
    endtask

    task automatic test_frame_load();
        logic [6:0] want [8];
        bit seen_wrap;
        int fd_cnt;
        want = '{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,
                 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        seen_wrap = 1'b0; fd_cnt = 0;
        wait_t(10);
        pulse_load(16'h1234);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                errors++; $display("FAIL frame_load_model an/seg/fd got %b/%b/%b want %b/%b/%b", bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
            if (m_show) begin
                checks++;
                if (bus.seg !== want[(seen_wrap ? 4 : 0) + m_slot]) begin
                    errors++; $display("FAIL frame_load_digit slot %0d got %b want %b", m_slot, bus.seg, want[(seen_wrap ? 4 : 0) + m_slot]);
                end
            end
            if (bus.frame_done === 1'b1) fd_cnt++;
            if (exp_fd) seen_wrap = 1'b1;
        end
        checks++;
        if (fd_cnt != 2) begin errors++; $display("FAIL frame_done_count got %0d want 2", fd_cnt); end
    endtask

    task automatic test_load_at_tick();
        logic [6:0] want [8];
        want = '{7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
                 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100};
        wait_t(3);
        pulse_load(16'h5678);
        wait_t(FRAME - 1);
        pulse_load(16'h9999);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                errors++; $display("FAIL tick_load_model an/seg/fd got %b/%b/%b want %b/%b/%b", bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
            if (m_show) begin
                checks++;
                if (bus.seg !== want[(i / FRAME) * 4 + m_slot]) begin
                    errors++; $display("FAIL tick_load_digit frame %0d slot %0d got %b want %b", i / FRAME, m_slot, bus.seg, want[(i / FRAME) * 4 + m_slot]);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] want [8];
        want = '{7'b0000001, 7'b0001111, 7'b1111111, 7'b1111111,
                 7'b0000001, 7'b0001111, 7'b0000001, 7'b0000001};
        bus.blank_lz = 1'b1;
        wait_t(5);
        pulse_load(16'h0070);
        wait_t(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                errors++; $display("FAIL lz_model an/seg/fd got %b/%b/%b want %b/%b/%b", bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
            if (m_show) begin
                checks++;
                if (bus.seg !== want[(i / FRAME) * 4 + m_slot]) begin
                    errors++; $display("FAIL lz_digit blank_lz %0d slot %0d got %b want %b", 1 - i / FRAME, m_slot, bus.seg, want[(i / FRAME) * 4 + m_slot]);
                end
            end
            if (i == FRAME - 1) bus.blank_lz = 1'b0;
        end
    endtask

    task automatic test_invalid_disable();
        logic [6:0] want [4];
        logic [3:0] hold_an;
        want = '{7'b0000001, 7'b1111111, 7'b0000001, 7'b0000001};
        wait_t(5);
        pulse_load(16'h00A0);
        wait_t(0);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                errors++; $display("FAIL invalid_model an/seg/fd got %b/%b/%b want %b/%b/%b", bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
            if (m_show) begin
                checks++;
                if (bus.seg !== want[m_slot]) begin errors++; $display("FAIL invalid_digit slot %0d got %b want %b", m_slot, bus.seg, want[m_slot]); end
            end
        end
        wait_t(20);
        hold_an = exp_an;
        bus.en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {4'hF, 7'h7F, 1'b0}) begin
                errors++; $display("FAIL disable_blank cycle %0d an/seg/fd got %b/%b/%b want 1111/1111111/0", i, bus.an, bus.seg, bus.frame_done);
            end
        end
        bus.en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.an !== hold_an) begin errors++; $display("FAIL resume_slot an got %b want %b", bus.an, hold_an); end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                errors++; $display("FAIL resume_model an/seg/fd got %b/%b/%b want %b/%b/%b", bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
        end
    endtask

    task automatic test_reset_midpend();
        wait_t(5);
        pulse_load(16'h8888);
        wait_t(12);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.an, bus.seg} !== {4'hF, 7'h7F}) begin errors++; $display("FAIL midreset_blank an/seg got %b/%b want 1111/1111111", bus.an, bus.seg); end
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                errors++; $display("FAIL midreset_model an/seg/fd got %b/%b/%b want %b/%b/%b", bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
            if (m_show) begin
                checks++;
                if (bus.seg !== 7'b0000001) begin errors++; $display("FAIL midreset_discard slot %0d got %b want 0000001", m_slot, bus.seg); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== {exp_an, exp_seg, exp_fd}) begin
                errors++; $display("FAIL random cycle %0d an/seg/fd got %b/%b/%b want %b/%b/%b", i, bus.an, bus.seg, bus.frame_done, exp_an, exp_seg, exp_fd);
            end
            bus.load = ($urandom_range(0, 19) == 0);
            bus.din  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 39) == 0) bus.en = ~bus.en;
            rst = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0; bus.en = 1'b1; bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_load();
        test_load_at_tick();
        test_lz();
        test_invalid_disable();
        test_reset_midpend();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
